// File: rtl/dmem_responder_if.sv
// Load/store handshake between the CPU data-memory port (master) and the
// memory responder (slave).
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  busy, ack, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output busy, ack, rdata, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-array data memory that services one request at a time with WAIT_CYCLES wait states.
// Optional misaligned-access error reporting is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             pcrst,
  dmem_responder_if.slave bus
);
  localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CntInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit          NoWait  = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [IdxW-1:0] idx_q;
  logic [1:0]      lo_q;
  logic            we_q;
  logic [31:0]     wdata_q;
  logic            busy_q;
  logic            ack_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            commit;
  logic            c_we;
  logic            c_mis;
  logic [IdxW-1:0] c_idx;
  logic [1:0]      c_lo;
  logic [31:0]     c_wdata;

  always_comb begin
    commit  = ((state_q == StIdle) && bus.req && NoWait) ||
              ((state_q == StWait) && (cnt_q == 4'd0));
    // With no wait states the commit edge is the acceptance edge, so live inputs are used.
    c_idx   = idx_q;
    c_lo    = lo_q;
    c_we    = we_q;
    c_wdata = wdata_q;
    if (state_q == StIdle) begin
      c_idx   = bus.addr[IdxW+1:2];
      c_lo    = bus.addr[1:0];
      c_we    = bus.we;
      c_wdata = bus.wdata;
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign c_mis = (c_lo != 2'b00);
`else
  assign c_mis = 1'b0;
  logic unused_lo;
  assign unused_lo = ^c_lo;
`endif

  logic unused_addr;
  assign unused_addr = ^bus.addr[31:IdxW+2];

  always_ff @(posedge clk) begin
    if (pcrst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (commit) begin
        ack_q <= 1'b1;
        err_q <= c_mis;
        if (!c_we) begin
          rdata_q <= c_mis ? 32'h0 : mem[c_idx];
        end
      end
      unique case (state_q)
        StIdle: begin
          if (bus.req) begin
            idx_q   <= bus.addr[IdxW+1:2];
            lo_q    <= bus.addr[1:0];
            we_q    <= bus.we;
            wdata_q <= bus.wdata;
            busy_q  <= 1'b1;
            if (NoWait) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array is not cleared by reset; a reset on the commit edge wins over the write.
  always_ff @(posedge clk) begin
    if (!pcrst && commit && c_we && !c_mis) begin
      mem[c_idx] <= c_wdata;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
endmodule
